leapfrog_window: RTL

LEAPFROG_WINDOW -- requirements
Module: leapfrog_window

---
 rtl/lc3b_types.sv | 50 +++++
 rtl/leapfrog_qualify.sv | 53 +++++
 rtl/leapfrog_window.sv | 102 ++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the leapfrog window: opcodes, register index,
// window states and opcode-class helpers.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAP = 2'd1,
    FULL = 2'd2
  } leap_state_e;

  function automatic logic is_load(input lc3b_opcode op);
    return (op == op_ldb) || (op == op_ldr) || (op == op_ldi);
  endfunction

  function automatic logic is_store(input lc3b_opcode op);
    return (op == op_stb) || (op == op_str) || (op == op_sti);
  endfunction

  function automatic logic is_trap(input lc3b_opcode op);
    return (op == op_trap);
  endfunction

  // Pure register-writing ALU ops whose result fully replaces the MEM write
  function automatic logic is_alu_writer(input lc3b_opcode op);
    return (op == op_add) || (op == op_and) || (op == op_not) ||
           (op == op_lea) || (op == op_shf);
  endfunction

endpackage

// File: rtl/leapfrog_qualify.sv
// Combinational qualification: decides whether the EX instruction may retire
// past the stalled MEM instruction and which kills it would set.
module leapfrog_qualify
  import lc3b_types::*;
#(
  parameter int unsigned CC_BYPASS = 1
) (
  input  logic       mem_stall,
  input  logic       ex_valid,
  input  logic       window_full,
  input  lc3b_opcode ex_opcode,
  input  lc3b_reg    ex_sr1,
  input  lc3b_reg    ex_sr2,
  input  lc3b_reg    ex_dest,
  input  logic       ex_dest_write,
  input  logic       ex_load_cc,
  input  lc3b_opcode mem_opcode,
  input  lc3b_reg    mem_dest,
  input  logic       mem_dest_write,
  input  logic       mem_load_cc,
  input  logic       dest_killed,
  input  logic       cc_killed,
  output logic       leapfrog_load,
  output logic       dest_kill_set,
  output logic       cc_kill_set,
  output logic       mem_hold
);

  logic ex_class_block;
  logic src_block;
  logic cc_block;

  assign ex_class_block = is_load(ex_opcode) || is_store(ex_opcode) || is_trap(ex_opcode);

  // Once the MEM destination has been overwritten, its stale value no longer matters
  assign src_block = mem_dest_write && !dest_killed &&
                     ((ex_sr1 == mem_dest) || (ex_sr2 == mem_dest));

  assign cc_block = (ex_opcode == op_br) && mem_load_cc &&
                    ((CC_BYPASS == 0) || !cc_killed);

  // Loads and traps in MEM must retire in order and keep their writes
  assign mem_hold = is_load(mem_opcode) || is_trap(mem_opcode);

  assign leapfrog_load = mem_stall && ex_valid && !window_full &&
                         !ex_class_block && !src_block && !cc_block && !mem_hold;

  assign dest_kill_set = leapfrog_load && ex_dest_write && mem_dest_write &&
                         (ex_dest == mem_dest) && is_alu_writer(ex_opcode);

  assign cc_kill_set = leapfrog_load && ex_load_cc;

endmodule

// File: rtl/leapfrog_window.sv
// Leapfrog window: tracks how many EX instructions have retired past a stalled
// MEM instruction and which of its writes they have made obsolete.
module leapfrog_window
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CC_BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_stall,
  input  logic                         ex_valid,
  input  lc3b_opcode                   ex_opcode,
  input  lc3b_reg                      ex_sr1,
  input  lc3b_reg                      ex_sr2,
  input  lc3b_reg                      ex_dest,
  input  logic                         ex_dest_write,
  input  logic                         ex_load_cc,
  input  lc3b_opcode                   mem_opcode,
  input  lc3b_reg                      mem_dest,
  input  logic                         mem_dest_write,
  input  logic                         mem_load_cc,
  output logic                         leapfrog_load,
  output logic                         mem_dest_overwrite,
  output logic                         mem_load_cc_overwrite,
  output logic [$clog2(DEPTH+1)-1:0]   leap_count,
  output logic                         window_full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  leap_state_e   state;
  logic          dest_killed;
  logic          cc_killed;
  logic          dest_kill_set;
  logic          cc_kill_set;
  logic          mem_hold;
  logic [CW-1:0] leap_next;

  leapfrog_qualify #(
    .CC_BYPASS (CC_BYPASS)
  ) u_qualify (
    .mem_stall      (mem_stall),
    .ex_valid       (ex_valid),
    .window_full    (window_full),
    .ex_opcode      (ex_opcode),
    .ex_sr1         (ex_sr1),
    .ex_sr2         (ex_sr2),
    .ex_dest        (ex_dest),
    .ex_dest_write  (ex_dest_write),
    .ex_load_cc     (ex_load_cc),
    .mem_opcode     (mem_opcode),
    .mem_dest       (mem_dest),
    .mem_dest_write (mem_dest_write),
    .mem_load_cc    (mem_load_cc),
    .dest_killed    (dest_killed),
    .cc_killed      (cc_killed),
    .leapfrog_load  (leapfrog_load),
    .dest_kill_set  (dest_kill_set),
    .cc_kill_set    (cc_kill_set),
    .mem_hold       (mem_hold)
  );

  assign leap_next = leap_count + CW'(1);

  // Window state, counter and kill bits; a bubble in EX freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      leap_count  <= '0;
      dest_killed <= 1'b0;
      cc_killed   <= 1'b0;
    end else if (!mem_stall) begin
      state       <= IDLE;
      leap_count  <= '0;
      dest_killed <= 1'b0;
      cc_killed   <= 1'b0;
    end else if (ex_valid) begin
      if (leapfrog_load && (leap_count != CW'(DEPTH))) begin
        leap_count <= leap_next;
      end
      if (dest_kill_set) begin
        dest_killed <= 1'b1;
      end
      if (cc_kill_set) begin
        cc_killed <= 1'b1;
      end
      if ((leapfrog_load && (leap_next == CW'(DEPTH))) || (leap_count == CW'(DEPTH))) begin
        state <= FULL;
      end else begin
        state <= LEAP;
      end
    end
  end

  assign window_full = (state == FULL);

  // Kills stay visible through the cycle the stall drops so the retiring write is squashed
  assign mem_dest_overwrite    = (dest_killed || dest_kill_set) && !mem_hold;
  assign mem_load_cc_overwrite = (cc_killed || cc_kill_set) && !mem_hold;

endmodule
